// File: rtl/reconstruct_audio_pkg.sv
// Shared types and helpers for the 24 kHz to 48 kHz playback reconstruction path.
package audio_pkg;

   typedef logic signed [15:0] sample_t;

   typedef enum logic [1:0] {
      PRIME = 2'd0,
      LOAD0 = 2'd1,
      LOAD1 = 2'd2,
      RUN   = 2'd3
   } state_t;

   localparam sample_t SAMPLE_MAX = 16'sh7fff;
   localparam sample_t SAMPLE_MIN = 16'sh8000;

   // Wide enough for a 16-bit sample shifted left by up to 4 bits.
   function automatic sample_t saturate16(input logic signed [20:0] x);
      if (x > 21'sd32767) begin
         return SAMPLE_MAX;
      end else if (x < -21'sd32768) begin
         return SAMPLE_MIN;
      end else begin
         return x[15:0];
      end
   endfunction

endpackage

// File: rtl/reconstruct_audio_fifo.sv
// Circular sample buffer; the head is readable combinationally so pop and capture share a cycle.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  sample_t                  wr_data,
   output sample_t                  rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   sample_t          mem_q [DEPTH];
   sample_t          mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full buffer still accepts a push when a pop frees a slot in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/reconstruct_audio.sv
// 2x linear-interpolating playback stage: buffers 24 kHz samples and emits one per 48 kHz DAC strobe.
//
// state | meaning
// PRIME | wait for two buffered samples; strobes answered with 0
// LOAD0 | pop first sample into prev
// LOAD1 | pop second sample into next, phase cleared
// RUN   | phase 0 emits prev, phase 1 emits midpoint and advances the pair
module reconstruct_audio
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAIN_SHIFT = 0
) (
   input  logic                            audio_clk,
   input  logic                            rst_in,
   input  logic                            sample_in_valid,
   input  logic signed [15:0]              sample_in,
   input  logic                            dac_trigger,
   input  logic                            mute,
   output logic signed [15:0]              audio_out,
   output logic                            audio_out_valid,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [15:0]                     underflow_count,
   output logic [15:0]                     overflow_count
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   state_t              state_q, state_d;
   logic                phase_q, phase_d;
   sample_t             prev_q, prev_d;
   sample_t             next_q, next_d;
   sample_t             out_q, out_d;
   logic                out_valid_q, out_valid_d;
   logic [15:0]         unf_q, unf_d;
   logic [15:0]         ovf_q, ovf_d;

   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push_drop;
   sample_t             fifo_head;
   logic [LW-1:0]       level;
   logic signed [16:0]  pair_sum;
   sample_t             pair_avg;
   sample_t             pick;
   logic signed [20:0]  pick_ext;
   logic signed [20:0]  scaled;

   sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (audio_clk),
      .rst     (rst_in),
      .push    (sample_in_valid),
      .pop     (fifo_pop),
      .wr_data (sample_in),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign push_drop = sample_in_valid & fifo_full & ~(fifo_pop & ~fifo_empty);

   // Dropping the LSB of the 17-bit sum is an arithmetic shift that floors toward -inf.
   assign pair_sum = {prev_q[15], prev_q} + {next_q[15], next_q};
   assign pair_avg = pair_sum[16:1];

   always_comb begin
      pick = '0;
      if (state_q == RUN) begin
         pick = phase_q ? pair_avg : prev_q;
      end
   end

   assign pick_ext = {{5{pick[15]}}, pick};
   assign scaled   = pick_ext <<< GAIN_SHIFT;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      prev_d      = prev_q;
      next_d      = next_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      unf_d       = unf_q;
      ovf_d       = ovf_q;
      fifo_pop    = 1'b0;

      unique case (state_q)
         PRIME: begin
            if (level >= LW'(2)) state_d = LOAD0;
         end
         LOAD0: begin
            fifo_pop = 1'b1;
            prev_d   = fifo_head;
            state_d  = LOAD1;
         end
         LOAD1: begin
            fifo_pop = 1'b1;
            next_d   = fifo_head;
            phase_d  = 1'b0;
            state_d  = RUN;
         end
         RUN: begin
            if (dac_trigger) begin
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d  = 1'b0;
                  prev_d   = next_q;
                  fifo_pop = 1'b1;
                  // Starved: repeat the last sample rather than restart priming.
                  if (fifo_empty) begin
                     if (unf_q != 16'hffff) unf_d = unf_q + 16'd1;
                  end else begin
                     next_d = fifo_head;
                  end
               end
            end
         end
      endcase

      if (dac_trigger) begin
         out_valid_d = 1'b1;
         out_d       = mute ? '0 : saturate16(scaled);
      end

      if (push_drop && (ovf_q != 16'hffff)) ovf_d = ovf_q + 16'd1;
   end

   always_ff @(posedge audio_clk) begin
      if (rst_in) begin
         state_q     <= PRIME;
         phase_q     <= 1'b0;
         prev_q      <= '0;
         next_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         unf_q       <= '0;
         ovf_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         prev_q      <= prev_d;
         next_q      <= next_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         unf_q       <= unf_d;
         ovf_q       <= ovf_d;
      end
   end

   assign audio_out       = out_q;
   assign audio_out_valid = out_valid_q;
   assign fifo_level      = level;
   assign underflow_count = unf_q;
   assign overflow_count  = ovf_q;

endmodule

// File: tb/tb_reconstruct_audio.sv
// Bench for reconstruct_audio: unity-gain and x4-gain instances share stimulus and a queue-based reference.
module tb_reconstruct_audio;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, vin, trig, mute;
   logic signed [15:0] sin;
   logic signed [15:0] out_a, out_g;
   logic               val_a, val_g;
   logic [2:0]         lvl_a, lvl_g;
   logic [15:0]        unf_a, unf_g, ovf_a, ovf_g;

   reconstruct_audio #(.FIFO_DEPTH(DEPTH), .GAIN_SHIFT(0)) dut (
      .audio_clk(clk), .rst_in(rst), .sample_in_valid(vin), .sample_in(sin),
      .dac_trigger(trig), .mute(mute), .audio_out(out_a), .audio_out_valid(val_a),
      .fifo_level(lvl_a), .underflow_count(unf_a), .overflow_count(ovf_a));

   reconstruct_audio #(.FIFO_DEPTH(DEPTH), .GAIN_SHIFT(2)) dut_g (
      .audio_clk(clk), .rst_in(rst), .sample_in_valid(vin), .sample_in(sin),
      .dac_trigger(trig), .mute(mute), .audio_out(out_g), .audio_out_valid(val_g),
      .fifo_level(lvl_g), .underflow_count(unf_g), .overflow_count(ovf_g));

   int checks = 0;
   int errors = 0;
   bit mute_lvl = 1'b0;

   // Reference model state: a sample queue plus the current interpolation pair.
   int q[$];
   int m_prev, m_next, m_phase, m_loads, m_unf, m_ovf;
   int e_out, e_outg;
   bit m_run, e_valid;

   typedef struct {
      bit push;
      int smp;
      bit trg;
      bit chk;
      int exp_out;
      int exp_unf;
   } vec_t;

   vec_t ramp[20];
   int   ov_exp[11] = '{1, 1, 2, 6, 10, 15, 20, 25, 30, 35, 40};

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int gain(int v, int sh);
      int y;
      y = v * (1 << sh);
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return y;
   endfunction

   function automatic int favg(int a, int b);
      int s;
      s = a + b;
      return (s - (s & 1)) / 2;
   endfunction

   task automatic model_step(bit r, bit p, int s, bit t, bit mu);
      int  lvl;
      int  smp;
      bit  was_run;
      if (r) begin
         q.delete();
         m_prev = 0; m_next = 0; m_phase = 0; m_loads = 0; m_unf = 0; m_ovf = 0;
         e_out = 0; e_outg = 0; e_valid = 0; m_run = 0;
         return;
      end
      lvl     = q.size();
      was_run = m_run;
      smp     = 0;
      if (t && was_run) begin
         if (m_phase == 0) begin
            smp     = m_prev;
            m_phase = 1;
         end else begin
            smp     = favg(m_prev, m_next);
            m_prev  = m_next;
            if (lvl > 0) m_next = q.pop_front();
            else if (m_unf < 65535) m_unf++;
            m_phase = 0;
         end
      end
      if (!was_run) begin
         if (m_loads == 2) begin
            m_prev  = q.pop_front();
            m_loads = 1;
         end else if (m_loads == 1) begin
            m_next  = q.pop_front();
            m_loads = 0;
            m_run   = 1;
            m_phase = 0;
         end else if (lvl >= 2) begin
            m_loads = 2;
         end
      end
      if (p) begin
         if (q.size() < DEPTH) q.push_back(s);
         else if (m_ovf < 65535) m_ovf++;
      end
      e_valid = t;
      if (t) begin
         e_out  = mu ? 0 : smp;
         e_outg = mu ? 0 : gain(smp, 2);
      end
   endtask

   task automatic step(bit r, bit p, int s, bit t, bit mu);
      rst  = r;
      vin  = p;
      sin  = 16'(s);
      trig = t;
      mute = mu;
      model_step(r, p, s, t, mu);
      @(posedge clk);
      #1;
      chk("valid", int'(val_a), int'(e_valid));
      chk("valid_g", int'(val_g), int'(e_valid));
      chk("out", out_a, e_out);
      chk("out_g", out_g, e_outg);
      chk("level", int'(lvl_a), q.size());
      chk("underflow", int'(unf_a), m_unf);
      chk("overflow", int'(ovf_a), m_ovf);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, mute_lvl);
   endtask

   task automatic push1(int s);
      step(0, 1, s, 0, mute_lvl);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0);
   endtask

   task automatic trig_exp(string name, int e, int eg);
      step(0, 0, 0, 1, mute_lvl);
      chk(name, out_a, e);
      chk({name, "_g"}, out_g, eg);
      chk({name, "_v"}, int'(val_a), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      ramp[0]  = '{1, 100, 0, 0, 0, 0};
      ramp[1]  = '{1, 200, 0, 0, 0, 0};
      ramp[2]  = '{0, 0, 0, 0, 0, 0};
      ramp[3]  = '{0, 0, 0, 0, 0, 0};
      ramp[4]  = '{0, 0, 0, 0, 0, 0};
      ramp[5]  = '{0, 0, 1, 1, 100, 0};
      ramp[6]  = '{1, 300, 0, 0, 0, 0};
      ramp[7]  = '{0, 0, 1, 1, 150, 0};
      ramp[8]  = '{1, 400, 0, 0, 0, 0};
      ramp[9]  = '{0, 0, 1, 1, 200, 0};
      ramp[10] = '{0, 0, 0, 0, 0, 0};
      ramp[11] = '{0, 0, 1, 1, 250, 0};
      ramp[12] = '{0, 0, 0, 0, 0, 0};
      ramp[13] = '{0, 0, 1, 1, 300, 0};
      ramp[14] = '{0, 0, 0, 0, 0, 0};
      ramp[15] = '{0, 0, 1, 1, 350, 1};
      ramp[16] = '{0, 0, 0, 0, 0, 0};
      ramp[17] = '{0, 0, 1, 1, 400, 1};
      ramp[18] = '{0, 0, 0, 0, 0, 0};
      ramp[19] = '{0, 0, 1, 1, 400, 2};

      // Reset state and a strobe while still priming.
      do_reset();
      chk("rst_out", out_a, 0);
      chk("rst_valid", int'(val_a), 0);
      chk("rst_level", int'(lvl_a), 0);
      chk("rst_unf", int'(unf_a), 0);
      chk("rst_ovf", int'(ovf_a), 0);
      trig_exp("prime_out", 0, 0);
      idle(1);

      // Ramp table.
      for (int i = 0; i < 20; i++) begin
         step(0, ramp[i].push, ramp[i].smp, ramp[i].trg, 0);
         if (ramp[i].chk) begin
            chk($sformatf("ramp_out%0d", i), out_a, ramp[i].exp_out);
            chk($sformatf("ramp_out_g%0d", i), out_g, gain(ramp[i].exp_out, 2));
            chk($sformatf("ramp_unf%0d", i), int'(unf_a), ramp[i].exp_unf);
         end
      end

      // Rounding toward -inf and full-scale average.
      do_reset();
      push1(-3); push1(0); idle(3);
      trig_exp("rnd_p0", -3, -12); idle(1);
      trig_exp("rnd_p1", -2, -8);
      do_reset();
      push1(32767); push1(32767); idle(3);
      trig_exp("max_p0", 32767, 32767); idle(1);
      trig_exp("max_p1", 32767, 32767);

      // Gain saturation on the x4 instance.
      do_reset();
      push1(10000); push1(-9000); push1(1000); idle(3);
      trig_exp("gain0", 10000, 32767); idle(1);
      trig_exp("gain1", 500, 2000); idle(1);
      trig_exp("gain2", -9000, -32768); idle(1);
      trig_exp("gain3", -4000, -16000); idle(1);
      trig_exp("gain4", 1000, 4000);

      // Starvation holds the last sample, then recovers without re-priming.
      do_reset();
      push1(100); push1(200); idle(3);
      trig_exp("unf_a", 100, 400); idle(1);
      trig_exp("unf_b", 150, 600); chk("unf_cnt1", int'(unf_a), 1); idle(1);
      trig_exp("unf_c", 200, 800); idle(1);
      trig_exp("unf_d", 200, 800); chk("unf_cnt2", int'(unf_a), 2); idle(1);
      push1(500); idle(1);
      trig_exp("unf_e", 200, 800); idle(1);
      trig_exp("unf_f", 200, 800); chk("unf_cnt3", int'(unf_a), 2); idle(1);
      trig_exp("unf_g", 200, 800); idle(1);
      trig_exp("unf_h", 350, 1400);

      // Overflow while running with no strobes.
      do_reset();
      push1(1); push1(2); idle(3);
      push1(10); push1(20); push1(30); push1(40); push1(50); push1(60);
      chk("ovf_level", int'(lvl_a), 4);
      chk("ovf_count", int'(ovf_a), 2);
      for (int i = 0; i < 11; i++) begin
         trig_exp($sformatf("ovf_seq%0d", i), ov_exp[i], gain(ov_exp[i], 2));
         idle(1);
      end

      // Mute keeps the interpolator advancing; reset mid-run clears everything.
      do_reset();
      push1(100); push1(200); push1(300); idle(3);
      trig_exp("mute_a", 100, 400); idle(1);
      mute_lvl = 1'b1;
      trig_exp("mute_b", 0, 0); idle(1);
      trig_exp("mute_c", 0, 0); idle(1);
      trig_exp("mute_d", 0, 0);
      chk("mute_unf", int'(unf_a), 1);
      mute_lvl = 1'b0;
      idle(1);
      trig_exp("mute_e", 300, 1200);
      step(1, 0, 0, 1, 0);
      chk("mrst_valid", int'(val_a), 0);
      chk("mrst_out", out_a, 0);
      chk("mrst_unf", int'(unf_a), 0);
      chk("mrst_level", int'(lvl_a), 0);
      trig_exp("mrst_prime", 0, 0);
      push1(7); push1(8); idle(3);
      trig_exp("mrst_first", 7, 28);

      // Randomized traffic against the reference model.
      begin
         bit last_t;
         bit r, p, t, mu;
         int s;
         last_t = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 699) == 0);
            p  = ($urandom_range(0, 9) < 3);
            t  = !last_t && ($urandom_range(0, 3) == 0);
            mu = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                              : int'($urandom_range(0, 16000)) - 8000;
            step(r, p, s, t, mu);
            last_t = t;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
